// File: rtl/display_page_selector.sv
// Display page selector: two debounced push-buttons step an 8-entry page
// index that picks which 16-bit half of a CPU debug word drives four
// seven-segment nibbles.
module display_page_selector #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [2:0]  page
);

  localparam int unsigned NUM_BTN  = 2;
  localparam int unsigned BTN_NEXT = 0;
  localparam int unsigned BTN_PREV = 1;
  localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] db;
  logic [NUM_BTN-1:0] db_delayed;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  logic [NUM_BTN-1:0] pulse_c;
  logic [15:0]        word_c;

  // Synchronize the raw buttons and debounce: a flip needs DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      db         <= '0;
      db_delayed <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      sync1      <= {btn_prev, btn_next};
      sync2      <= sync1;
      db_delayed <= db;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press pulses come straight from registered state so a rising debounced
  // level steps the page on the very next edge.
  assign pulse_c = db & ~db_delayed;

  // Page index: next/prev wrap modulo 8; simultaneous presses cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      page <= '0;
    end else begin
      case ({pulse_c[BTN_PREV], pulse_c[BTN_NEXT]})
        2'b01:   page <= page + 3'd1;
        2'b10:   page <= page - 3'd1;
        default: page <= page;
      endcase
    end
  end

  // Page map: even pages show the upper half-word, odd pages the lower.
  always_comb begin
    word_c = 16'h0000;
    case (page)
      3'd0:    word_c = pc[31:16];
      3'd1:    word_c = pc[15:0];
      3'd2:    word_c = instr[31:16];
      3'd3:    word_c = instr[15:0];
      3'd4:    word_c = aluout[31:16];
      3'd5:    word_c = aluout[15:0];
      3'd6:    word_c = writedata[31:16];
      default: word_c = writedata[15:0];
    endcase
  end

  // Display nibbles are refreshed every cycle so live data is tracked.
  always_ff @(posedge clk) begin
    if (reset) begin
      {hex3, hex2, hex1, hex0} <= 16'h0000;
    end else begin
      {hex3, hex2, hex1, hex0} <= word_c;
    end
  end

endmodule

// File: tb/tb_display_page_selector.sv
// Bench for display_page_selector: expectations are queued with the cycle at
// which they must hold and compared on the falling edge of that cycle.
module tb_display_page_selector;

  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_next;
  logic        btn_prev;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [3:0]  hex3, hex2, hex1, hex0;
  logic [2:0]  page;

  display_page_selector #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .pc(pc), .instr(instr), .aluout(aluout), .writedata(writedata),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .page(page)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_hex;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_page = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Insert keeping the queue ordered by due cycle.
  task automatic expect_at(input int c, input bit is_hex, input logic [15:0] v, input string tag);
    exp_t e;
    int   idx;
    e.cyc = c; e.is_hex = is_hex; e.val = v; e.tag = tag;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  // Compare every expectation due on this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.is_hex) check_eq(e.tag, 32'({hex3, hex2, hex1, hex0}), 32'(e.val));
      else          check_eq(e.tag, 32'(page), 32'(e.val));
    end
  end

  function automatic logic [15:0] page_word(input int p);
    case (p)
      0:       return pc[31:16];
      1:       return pc[15:0];
      2:       return instr[31:16];
      3:       return instr[15:0];
      4:       return aluout[31:16];
      5:       return aluout[15:0];
      6:       return writedata[31:16];
      default: return writedata[15:0];
    endcase
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press (and later release) buttons; a lone press steps the page at E0+DB+2.
  task automatic press(input bit nxt, input bit prv, input string tag);
    int t;
    int np;
    t  = cyc;
    np = cur_page;
    if (nxt && !prv) np = (cur_page + 1) % 8;
    if (prv && !nxt) np = (cur_page + 7) % 8;
    btn_next = nxt;
    btn_prev = prv;
    expect_at(t + DB + 2, 1'b0, 16'(cur_page), {tag, "_before"});
    expect_at(t + DB + 3, 1'b0, 16'(np),       {tag, "_step"});
    expect_at(t + DB + 4, 1'b1, page_word(np), {tag, "_hex"});
    expect_at(t + 20,     1'b0, 16'(np),       {tag, "_held"});
    tick(20);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    expect_at(cyc + 12, 1'b0, 16'(np), {tag, "_released"});
    tick(12);
    cur_page = np;
  endtask

  initial begin
    int t;
    reset     = 1'b1;
    btn_next  = 1'b0;
    btn_prev  = 1'b0;
    pc        = 32'h0040_1234;
    instr     = 32'h89AB_CDEF;
    aluout    = 32'hDEAD_BEEF;
    writedata = 32'h1357_2468;
    tick(3);
    expect_at(cyc, 1'b0, 16'h0, "rst_page");
    expect_at(cyc, 1'b1, 16'h0, "rst_hex");
    tick(1);

    // Release: the first edge loads pc[31:16].
    reset = 1'b0;
    expect_at(cyc + 1, 1'b1, 16'h0040, "rel_hex_pc_hi");
    expect_at(cyc + 1, 1'b0, 16'h0,    "rel_page");
    tick(2);

    press(1'b1, 1'b0, "next_0to1");
    press(1'b1, 1'b0, "next_1to2");

    // Bouncy button: high 3 cycles, low 1, never long enough to flip.
    t = cyc;
    for (int r = 0; r < 6; r++) begin
      btn_next = 1'b1;
      tick(3);
      btn_next = 1'b0;
      tick(1);
    end
    expect_at(t + 12, 1'b0, 16'd2, "glitch_mid");
    expect_at(cyc + 8, 1'b0, 16'd2, "glitch_end");
    tick(8);

    press(1'b0, 1'b1, "prev_2to1");
    press(1'b0, 1'b1, "prev_1to0");
    press(1'b0, 1'b1, "prev_wrap_0to7");
    press(1'b1, 1'b0, "next_wrap_7to0");
    press(1'b1, 1'b1, "both_cancel");

    // Reset two cycles into a held press discards the partial count.
    btn_next = 1'b1;
    tick(2);
    reset = 1'b1;
    expect_at(cyc + 2, 1'b0, 16'h0, "midrst_page");
    expect_at(cyc + 2, 1'b1, 16'h0, "midrst_hex");
    tick(2);
    reset = 1'b0;
    t = cyc;
    expect_at(t + 1,      1'b1, 16'h0040, "midrst_rel_hex");
    expect_at(t + DB + 2, 1'b0, 16'd0,    "midrst_hold0");
    expect_at(t + DB + 3, 1'b0, 16'd1,    "midrst_step");
    expect_at(t + 20,     1'b0, 16'd1,    "midrst_once");
    tick(20);
    btn_next = 1'b0;
    tick(12);
    cur_page = 1;

    press(1'b1, 1'b0, "next_1to2b");
    press(1'b1, 1'b0, "next_2to3");
    press(1'b1, 1'b0, "next_3to4");

    // Live data tracking on page 4.
    expect_at(cyc, 1'b1, 16'hDEAD, "alu_old");
    aluout = 32'hCAFE_F00D;
    expect_at(cyc + 1, 1'b1, 16'hCAFE, "alu_new");
    tick(3);
    press(1'b1, 1'b0, "next_4to5");

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
